// File: rtl/heartaware_pkg.sv
// Shared display/sample constants and raster payload types for the heart-trace pipeline.
package heartaware_pkg;

    localparam int unsigned SCREEN_W    = 1024;
    localparam int unsigned SCREEN_H    = 768;
    localparam int unsigned SAMPLE_W    = 8;
    localparam int unsigned HCOUNT_W    = 11;
    localparam int unsigned VCOUNT_W    = 10;
    localparam int unsigned WAVE_DECIM  = 4;

    localparam logic [SAMPLE_W-1:0] WAVE_BASELINE = 8'd128;

    // Raster position travelling alongside pixel data
    typedef struct packed {
        logic [HCOUNT_W-1:0] hcount;
        logic [VCOUNT_W-1:0] vcount;
    } raster_t;

endpackage : heartaware_pkg

// File: rtl/waveform_ram.sv
// Simple dual-port sample RAM: one write port, one registered read-first read port.
module waveform_ram #(
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clock,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Write and registered read in one process so a same-address read returns old data
    always_ff @(posedge clock) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        rd_data_o <= mem_q[rd_addr_i];
    end

endmodule : waveform_ram

// File: rtl/waveform_sample_buffer.sv
// Circular sample store replaying one sample per pixel column, oldest sample at column 0.
// Optional decimation of incoming samples is enabled by defining WAVEFORM_DECIM_EN.
module waveform_sample_buffer
    import heartaware_pkg::*;
#(
    parameter int unsigned         WIDTH    = SCREEN_W,
    parameter int unsigned         ADDR_W   = $clog2(WIDTH),
    parameter int unsigned         DATA_W   = SAMPLE_W,
    parameter logic [DATA_W-1:0]   BASELINE = WAVE_BASELINE
`ifdef WAVEFORM_DECIM_EN
    ,
    parameter int unsigned         DECIM    = WAVE_DECIM
`endif
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                sample_valid,
    input  logic [DATA_W-1:0]   sample_in,
    input  logic                freeze,
    input  logic [HCOUNT_W-1:0] hcount,
    input  logic [VCOUNT_W-1:0] vcount,
    output logic [DATA_W-1:0]   signal_out,
    output logic [HCOUNT_W-1:0] hcount_d,
    output logic [VCOUNT_W-1:0] vcount_d,
    output logic                out_valid
);

    localparam int unsigned FILL_W = ADDR_W + 1;

    logic [ADDR_W-1:0] wr_ptr_q,     wr_ptr_d;
    logic [FILL_W-1:0] fill_q,       fill_d;
    logic [ADDR_W-1:0] frame_base_q, frame_base_d;
    logic [FILL_W-1:0] fill_f_q,     fill_f_d;

    logic              accept_c;
    logic              wr_en_c;
    logic              frame_start_c;
    logic [ADDR_W-1:0] rd_addr_c;
    logic              col_ok_d;

    logic              col_ok_q;
    raster_t           raster1_q;
    raster_t           raster2_q;
    logic [DATA_W-1:0] signal_out_q;
    logic              out_valid_q;
    logic [DATA_W-1:0] rdata;

    // A strobe counts as accepted whenever the screen is not held
    assign accept_c = sample_valid & ~freeze;

`ifdef WAVEFORM_DECIM_EN
    localparam int unsigned DCNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;

    logic [DCNT_W-1:0] decim_cnt_q, decim_cnt_d;

    // Decimation counter advances on accepted strobes only, so it holds during freeze
    always_comb begin
        decim_cnt_d = decim_cnt_q;
        if (accept_c) begin
            decim_cnt_d = (decim_cnt_q == DCNT_W'(DECIM - 1)) ? '0 : decim_cnt_q + 1'b1;
        end
    end

    assign wr_en_c = accept_c && (decim_cnt_q == '0);

    // Decimation counter register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            decim_cnt_q <= '0;
        end else begin
            decim_cnt_q <= decim_cnt_d;
        end
    end
`else
    assign wr_en_c = accept_c;
`endif

    // Write pointer, saturating fill count and start-of-frame snapshot
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        fill_d       = fill_q;
        frame_base_d = frame_base_q;
        fill_f_d     = fill_f_q;

        if (wr_en_c) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (fill_q != FILL_W'(WIDTH)) begin
                fill_d = fill_q + 1'b1;
            end
        end

        // Snapshot uses pre-write values, so a frame-start write lands in the next frame
        if (frame_start_c) begin
            frame_base_d = (fill_q == FILL_W'(WIDTH)) ? wr_ptr_q : '0;
            fill_f_d     = fill_q;
        end
    end

    assign frame_start_c = (hcount == '0) && (vcount == '0);

    // Column 0 must already see the new frame's snapshot, hence the _d values here
    assign rd_addr_c = frame_base_d + hcount[ADDR_W-1:0];
    assign col_ok_d  = (32'(hcount) < WIDTH) && (32'(hcount) < 32'(fill_f_d));

    // Pointer and frame-snapshot registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q     <= '0;
            fill_q       <= '0;
            frame_base_q <= '0;
            fill_f_q     <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            fill_q       <= fill_d;
            frame_base_q <= frame_base_d;
            fill_f_q     <= fill_f_d;
        end
    end

    waveform_ram #(
        .DEPTH  (WIDTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clock     (clock),
        .wr_en_i   (wr_en_c),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (sample_in),
        .rd_addr_i (rd_addr_c),
        .rd_data_o (rdata)
    );

    // Two-stage read pipeline: address/column-valid stage, then data/baseline select
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            col_ok_q     <= 1'b0;
            raster1_q    <= '0;
            raster2_q    <= '0;
            signal_out_q <= BASELINE;
            out_valid_q  <= 1'b0;
        end else begin
            col_ok_q     <= col_ok_d;
            raster1_q    <= '{hcount: hcount, vcount: vcount};
            raster2_q    <= raster1_q;
            signal_out_q <= col_ok_q ? rdata : BASELINE;
            out_valid_q  <= col_ok_q;
        end
    end

    assign signal_out = signal_out_q;
    assign out_valid  = out_valid_q;
    assign hcount_d   = raster2_q.hcount;
    assign vcount_d   = raster2_q.vcount;

endmodule : waveform_sample_buffer

// File: tb/tb_waveform_sample_buffer.sv
// Scoreboard bench for waveform_sample_buffer: stimulus queues expected pixels, monitor checks them.
module tb_waveform_sample_buffer;
    import heartaware_pkg::*;

    localparam int unsigned W = SCREEN_W;

    logic                clock        = 1'b0;
    logic                reset_n      = 1'b0;
    logic                sample_valid = 1'b0;
    logic [7:0]          sample_in    = 8'd0;
    logic                freeze       = 1'b0;
    logic [HCOUNT_W-1:0] hcount       = 11'd1100;
    logic [VCOUNT_W-1:0] vcount       = 10'd5;
    logic [7:0]          signal_out;
    logic [HCOUNT_W-1:0] hcount_d;
    logic [VCOUNT_W-1:0] vcount_d;
    logic                out_valid;

    typedef struct {
        int         due;
        logic [7:0] sig;
        logic       vld;
        logic [10:0] h;
        logic [9:0] v;
    } exp_t;

    exp_t sb[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clock = ~clock;

    waveform_sample_buffer dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .sample_valid (sample_valid),
        .sample_in    (sample_in),
        .freeze       (freeze),
        .hcount       (hcount),
        .vcount       (vcount),
        .signal_out   (signal_out),
        .hcount_d     (hcount_d),
        .vcount_d     (vcount_d),
        .out_valid    (out_valid)
    );

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    // Monitor: pop every expectation whose output cycle has arrived
    always @(negedge clock) begin
        while (sb.size() > 0 && sb[0].due == cyc) begin
            exp_t e;
            e = sb.pop_front();
            check($sformatf("signal_out col %0d line %0d", e.h, e.v), 32'(signal_out), 32'(e.sig));
            check($sformatf("out_valid col %0d line %0d", e.h, e.v), 32'(out_valid), 32'(e.vld));
            check($sformatf("hcount_d col %0d", e.h), 32'(hcount_d), 32'(e.h));
            check($sformatf("vcount_d col %0d", e.h), 32'(vcount_d), 32'(e.v));
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            hcount = 11'd1100;
            vcount = 10'd5;
            tick();
        end
    endtask

    // Present one pixel and queue its expected output two cycles later
    task automatic pix(input int h, input int v, input logic [7:0] sig, input logic vld);
        exp_t e;
        hcount = 11'(h);
        vcount = 10'(v);
        e.due = cyc + 2;
        e.sig = sig;
        e.vld = vld;
        e.h   = 11'(h);
        e.v   = 10'(v);
        sb.push_back(e);
        tick();
    endtask

    task automatic write_sample(input logic [7:0] val);
        hcount       = 11'd1100;
        vcount       = 10'd5;
        sample_valid = 1'b1;
        sample_in    = val;
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic do_reset();
        idle(3);
        reset_n = 1'b0;
        #2;
        check("reset signal_out", 32'(signal_out), 32'd128);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset hcount_d", 32'(hcount_d), 32'd0);
        check("reset vcount_d", 32'(vcount_d), 32'd0);
        tick();
        tick();
        reset_n = 1'b1;
        idle(2);
    endtask

    initial begin
        idle(2);
        do_reset();

        // Empty buffer: every column is baseline, off-trace too
        for (int c = 0; c < int'(W); c++) pix(c, 0, 8'd128, 1'b0);
        for (int c = int'(W); c < int'(W) + 8; c++) pix(c, 0, 8'd128, 1'b0);
        idle(3);

`ifdef WAVEFORM_DECIM_EN
        // Decimation keeps strobes 0,4,8,12
        do_reset();
        for (int i = 0; i < 16; i++) write_sample(8'(i));
        for (int c = 0; c < 8; c++) begin
            if (c < 4) pix(c, 0, 8'(c * 4), 1'b1);
            else       pix(c, 0, 8'd128, 1'b0);
        end
        idle(3);
`else
        // Partial fill, with a write at frame start that must not appear this frame
        for (int i = 0; i < 10; i++) write_sample(8'(i));
        for (int c = 0; c < 16; c++) begin
            if (c == 0) begin
                sample_valid = 1'b1;
                sample_in    = 8'hAA;
            end
            if (c < 10) pix(c, 0, 8'(c), 1'b1);
            else        pix(c, 0, 8'd128, 1'b0);
            sample_valid = 1'b0;
        end
        idle(3);
        for (int c = 0; c < 12; c++) begin
            if (c < 10)       pix(c, 0, 8'(c), 1'b1);
            else if (c == 10) pix(c, 0, 8'hAA, 1'b1);
            else              pix(c, 0, 8'd128, 1'b0);
        end
        idle(3);

        // Wrap: 1030 samples, column c shows sample index c+6
        do_reset();
        for (int i = 0; i < 1030; i++) write_sample(8'(i));
        for (int c = 0; c < int'(W); c++) pix(c, 0, 8'(c + 6), 1'b1);
        for (int c = int'(W); c < int'(W) + 6; c++) pix(c, 0, 8'd128, 1'b0);
        idle(3);

        // Freeze: incoming samples discarded, frame unchanged
        freeze = 1'b1;
        for (int i = 0; i < 50; i++) write_sample(8'hEE);
        for (int c = 0; c < int'(W); c++) pix(c, 0, 8'(c + 6), 1'b1);
        idle(3);
        freeze = 1'b0;

        // One more sample after release scrolls the trace by one
        write_sample(8'h77);
        pix(0, 0, 8'd7, 1'b1);
        pix(1, 0, 8'd8, 1'b1);
        pix(1022, 0, 8'd5, 1'b1);
        pix(1023, 0, 8'h77, 1'b1);
        pix(7, 3, 8'd14, 1'b1);
        idle(3);

        // Reset mid-operation empties the trace
        do_reset();
        for (int c = 0; c < 32; c++) pix(c, 0, 8'd128, 1'b0);
        pix(1023, 0, 8'd128, 1'b0);
        idle(3);
`endif

        idle(4);
        check("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_waveform_sample_buffer
